// File: rtl/ift_pkg.sv
// Shared taint types and helpers for the IFT storage blocks.
// Labels combine by bitwise OR; TAINT_W is the widest label the helpers carry.
package ift_pkg;
    localparam int TAINT_W = 32;
    typedef logic [TAINT_W-1:0] taint_t;
    localparam taint_t TAINT_NONE = '0;

    function automatic taint_t taint_or3(input taint_t a, input taint_t b, input taint_t c);
        return a | b | c;
    endfunction
endpackage

// File: rtl/ift_sync_fifo_if.sv
// Write/read/status bundle of the taint-tracking FIFO.
// master drives requests and samples status; slave is the FIFO itself.
interface ift_sync_fifo_if #(
    parameter int WIDTH = 2,
    parameter int TW    = 32,
    parameter int CW    = 3
);
    logic             wr_en;
    logic [TW-1:0]    wr_en_t;
    logic [WIDTH-1:0] wr_data;
    logic [TW-1:0]    wr_data_t;
    logic             rd_en;
    logic [TW-1:0]    rd_en_t;
    logic [WIDTH-1:0] rd_data;
    logic [TW-1:0]    rd_data_t;
    logic             full;
    logic             empty;
    logic [TW-1:0]    flags_t;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             udf;

    modport master (
        output wr_en, wr_en_t, wr_data, wr_data_t, rd_en, rd_en_t,
        input  rd_data, rd_data_t, full, empty, flags_t, count, ovf, udf
    );
    modport slave (
        input  wr_en, wr_en_t, wr_data, wr_data_t, rd_en, rd_en_t,
        output rd_data, rd_data_t, full, empty, flags_t, count, ovf, udf
    );
endinterface

// File: rtl/ift_fifo_ctrl.sv
// FIFO bookkeeping: pointers, occupancy, sticky error flags and control taint.
// Latency: accept decisions combinational, state updates on the next edge.
// Backpressure: writes refused when full unless a read frees a slot; reads refused when empty.
module ift_fifo_ctrl
    import ift_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TW    = TAINT_W,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [TW-1:0] wr_en_t,
    input  logic          rd_en,
    input  logic [TW-1:0] rd_en_t,
    output logic          wa,
    output logic          ra,
    output logic [PW-1:0] wp,
    output logic [PW-1:0] rp,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          udf,
    output logic [TW-1:0] ctrl_t
);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic [TW-1:0] ctrl_t_q, ctrl_t_d;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign ra    = rd_en & ~empty;
    assign wa    = wr_en & (~full | ra);

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (wa) wp_d = wp_q + PTR_ONE;
        if (ra) rp_d = rp_q + PTR_ONE;
        case ({wa, ra})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | (wr_en & full & ~rd_en);
        udf_d = udf_q | (rd_en & empty);
        // Enables steer pointer state whatever their value, so their taint always accrues.
        ctrl_t_d = TW'(taint_or3(taint_t'(ctrl_t_q), taint_t'(wr_en_t), taint_t'(rd_en_t)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q     <= '0;
            rp_q     <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            ctrl_t_q <= TW'(TAINT_NONE);
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            ctrl_t_q <= ctrl_t_d;
        end
    end

    assign wp     = wp_q;
    assign rp     = rp_q;
    assign count  = count_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;
    assign ctrl_t = ctrl_t_q;
endmodule

// File: rtl/ift_sync_fifo.sv
// Taint-tracking synchronous FIFO: data/taint storage plus registered read port.
// Latency: read data valid the cycle after an accepted read, no fall-through.
// Backpressure: refused writes/reads leave state untouched and raise sticky ovf/udf.
module ift_sync_fifo
    import ift_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int TW    = TAINT_W
) (
    input logic            clk,
    input logic            rst_n,
    ift_sync_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          wa, ra, full, empty, ovf, udf;
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] count;
    logic [TW-1:0] ctrl_t;

    logic [WIDTH-1:0] mem_q   [DEPTH];
    logic [WIDTH-1:0] mem_d   [DEPTH];
    logic [TW-1:0]    mem_t_q [DEPTH];
    logic [TW-1:0]    mem_t_d [DEPTH];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [TW-1:0]    rd_data_t_q, rd_data_t_d;

    ift_fifo_ctrl #(.DEPTH(DEPTH), .TW(TW)) u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_en_t (bus.wr_en_t),
        .rd_en   (bus.rd_en),
        .rd_en_t (bus.rd_en_t),
        .wa      (wa),
        .ra      (ra),
        .wp      (wp),
        .rp      (rp),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .ovf     (ovf),
        .udf     (udf),
        .ctrl_t  (ctrl_t)
    );

    always_comb begin
        mem_d       = mem_q;
        mem_t_d     = mem_t_q;
        rd_data_d   = rd_data_q;
        rd_data_t_d = rd_data_t_q;
        if (wa) begin
            mem_d[wp]   = bus.wr_data;
            mem_t_d[wp] = TW'(taint_or3(taint_t'(bus.wr_data_t), taint_t'(bus.wr_en_t),
                                        taint_t'(ctrl_t)));
        end
        // Read uses pre-write contents: on a full wrap wp == rp, and the old entry must leave first.
        if (ra) begin
            rd_data_d   = mem_q[rp];
            rd_data_t_d = TW'(taint_or3(taint_t'(mem_t_q[rp]), taint_t'(bus.rd_en_t),
                                        taint_t'(ctrl_t)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i]   <= '0;
                mem_t_q[i] <= TW'(TAINT_NONE);
            end
            rd_data_q   <= '0;
            rd_data_t_q <= TW'(TAINT_NONE);
        end else begin
            mem_q       <= mem_d;
            mem_t_q     <= mem_t_d;
            rd_data_q   <= rd_data_d;
            rd_data_t_q <= rd_data_t_d;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_data_t = rd_data_t_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.flags_t   = ctrl_t;
    assign bus.count     = count;
    assign bus.ovf       = ovf;
    assign bus.udf       = udf;
endmodule

// File: tb/tb_ift_sync_fifo.sv
// Bench for ift_sync_fifo: queue-based reference plus directed vectors with literal expectations.
module tb_ift_sync_fifo;
    localparam int WIDTH = 2;
    localparam int DEPTH = 4;
    localparam int TW    = 32;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ift_sync_fifo_if #(.WIDTH(WIDTH), .TW(TW), .CW(CW)) bus ();

    ift_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TW(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of (data, label) entries and plain status variables.
    typedef struct {
        logic [WIDTH-1:0] d;
        logic [TW-1:0]    t;
    } entry_t;
    entry_t           q[$];
    logic [WIDTH-1:0] m_rd   = '0;
    logic [TW-1:0]    m_rdt  = '0;
    logic [TW-1:0]    m_ctrl = '0;
    bit               m_ovf  = 0;
    bit               m_udf  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_rd = '0; m_rdt = '0; m_ctrl = '0; m_ovf = 0; m_udf = 0;
        end else begin
            automatic bit do_rd = bus.rd_en && q.size() > 0;
            automatic bit do_wr = bus.wr_en && (q.size() < DEPTH || do_rd);
            automatic logic [TW-1:0] c = m_ctrl;
            if (bus.wr_en && q.size() == DEPTH && !bus.rd_en) m_ovf = 1;
            if (bus.rd_en && q.size() == 0) m_udf = 1;
            if (do_rd) begin
                automatic entry_t e = q.pop_front();
                m_rd  = e.d;
                m_rdt = e.t | bus.rd_en_t | c;
            end
            if (do_wr) begin
                automatic entry_t n;
                n.d = bus.wr_data;
                n.t = bus.wr_data_t | bus.wr_en_t | c;
                q.push_back(n);
            end
            m_ctrl = c | bus.wr_en_t | bus.rd_en_t;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("cmp_rd_data",   bus.rd_data,   m_rd);
            check("cmp_rd_data_t", bus.rd_data_t, m_rdt);
            check("cmp_count",     bus.count,     q.size());
            check("cmp_full",      bus.full,      q.size() == DEPTH);
            check("cmp_empty",     bus.empty,     q.size() == 0);
            check("cmp_flags_t",   bus.flags_t,   m_ctrl);
            check("cmp_ovf",       bus.ovf,       m_ovf);
            check("cmp_udf",       bus.udf,       m_udf);
        end
    end

    task automatic idle_inputs();
        bus.wr_en = 0; bus.wr_en_t = '0; bus.wr_data = '0; bus.wr_data_t = '0;
        bus.rd_en = 0; bus.rd_en_t = '0;
    endtask

    // One clock with the given request, then observe just after the edge.
    task automatic op(input bit we, input logic [WIDTH-1:0] wd, input logic [TW-1:0] wdt,
                      input logic [TW-1:0] wet, input bit re, input logic [TW-1:0] ret);
        bus.wr_en = we; bus.wr_data = wd; bus.wr_data_t = wdt; bus.wr_en_t = wet;
        bus.rd_en = re; bus.rd_en_t = ret;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        do_reset();

        // Reset state and plain in-order traffic
        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_rd_data", bus.rd_data, 0);
        for (int i = 0; i < 4; i++) op(1, 2'(i), '0, '0, 0, '0);
        check("t1_count_full", bus.count, 4);
        check("t1_full", bus.full, 1);
        for (int i = 0; i < 4; i++) begin
            op(0, '0, '0, '0, 1, '0);
            check("t1_rd_data", bus.rd_data, i);
            check("t1_count", bus.count, 3 - i);
            check("t1_rd_data_t", bus.rd_data_t, 0);
        end
        check("t1_empty", bus.empty, 1);

        // Explicit and implicit taint through one entry
        do_reset();
        op(1, 2'b01, 32'h1, 32'h4, 0, '0);
        op(0, '0, '0, '0, 1, 32'h10);
        check("t2_rd_data", bus.rd_data, 1);
        check("t2_rd_data_t", bus.rd_data_t, 32'h15);
        check("t2_flags_t", bus.flags_t, 32'h14);

        // Overflow, then simultaneous read/write while full across the wrap
        do_reset();
        op(1, 2'd3, '0, '0, 0, '0);
        op(1, 2'd2, '0, '0, 0, '0);
        op(1, 2'd1, '0, '0, 0, '0);
        op(1, 2'd0, '0, '0, 0, '0);
        op(1, 2'd2, '0, '0, 0, '0);
        check("t3_ovf", bus.ovf, 1);
        check("t3_ovf_count", bus.count, 4);
        op(1, 2'd1, '0, '0, 1, '0);
        check("t3_rw_full_rd", bus.rd_data, 3);
        check("t3_rw_full_count", bus.count, 4);
        op(0, '0, '0, '0, 1, '0); check("t3_wrap_rd0", bus.rd_data, 2);
        op(0, '0, '0, '0, 1, '0); check("t3_wrap_rd1", bus.rd_data, 1);
        op(0, '0, '0, '0, 1, '0); check("t3_wrap_rd2", bus.rd_data, 0);
        op(0, '0, '0, '0, 1, '0); check("t3_wrap_rd3", bus.rd_data, 1);
        check("t3_udf_clear", bus.udf, 0);

        // Underflow holds rd_data; write+read on empty only writes
        do_reset();
        op(1, 2'd2, '0, '0, 0, '0);
        op(0, '0, '0, '0, 1, '0);
        op(0, '0, '0, '0, 1, '0);
        check("t4_udf", bus.udf, 1);
        check("t4_rd_hold", bus.rd_data, 2);
        op(1, 2'd3, '0, '0, 1, '0);
        check("t4_rw_empty_count", bus.count, 1);
        check("t4_rw_empty_rd", bus.rd_data, 2);
        op(0, '0, '0, '0, 1, '0);
        check("t4_rd_after", bus.rd_data, 3);

        // Idle-cycle enable taint is sticky and leaks into data
        do_reset();
        op(0, '0, '0, '0, 0, 32'h2);
        check("t5_flags_idle", bus.flags_t, 32'h2);
        op(1, 2'd1, '0, '0, 0, '0);
        op(0, '0, '0, '0, 1, '0);
        check("t5_rd_data_t", bus.rd_data_t, 32'h2);
        repeat (3) op(0, '0, '0, '0, 0, '0);
        check("t5_flags_sticky", bus.flags_t, 32'h2);
        do_reset();
        check("t5_flags_rst", bus.flags_t, 0);

        // Asynchronous reset between edges with three entries held
        op(1, 2'd1, '0, 32'h8, 0, '0);
        op(1, 2'd2, '0, '0, 0, '0);
        op(1, 2'd3, '0, '0, 0, '0);
        op(1, 2'd3, '0, '0, 0, '0);
        op(0, '0, '0, '0, 1, '0);
        check("t6_pre_count", bus.count, 3);
        check("t6_pre_rd", bus.rd_data, 1);
        #2 rst_n = 0;
        #1;
        check("t6_arst_count", bus.count, 0);
        check("t6_arst_empty", bus.empty, 1);
        check("t6_arst_full", bus.full, 0);
        check("t6_arst_rd", bus.rd_data, 0);
        check("t6_arst_rd_t", bus.rd_data_t, 0);
        check("t6_arst_flags", bus.flags_t, 0);
        @(posedge clk);
        #1 rst_n = 1;
        op(0, '0, '0, '0, 1, '0);
        check("t6_post_udf", bus.udf, 1);
        check("t6_post_rd", bus.rd_data, 0);
        check("t6_post_count", bus.count, 0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ift_sync_fifo.md
Name: ift_sync_fifo

Overview:
- Parametrised, synchronous, taint-tracking storage element for the IFT flow; the clocked, multi-entry successor to the enable-controlled D latch.
- Stores WIDTH-bit data words. Each word carries a TW-bit taint label; labels combine by bitwise OR.
- Control taint propagates implicitly into storage, flags and read data, so the taint-analysis benches can check explicit and implicit flows through a buffer.

Parameters:
- WIDTH, 2, data word width in bits.
- DEPTH, 4, number of entries; power of two, at least 2.
- TW, 32, taint label width per signal.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_en_t  in  TW  taint of wr_en.
- wr_data  in  WIDTH  write data.
- wr_data_t  in  TW  taint of wr_data.
- rd_en  in  1  read request.
- rd_en_t  in  TW  taint of rd_en.
- rd_data  out  WIDTH  registered read data.
- rd_data_t  out  TW  taint of rd_data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- flags_t  out  TW  taint of full, empty and count.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- ovf  out  1  sticky overflow error.
- udf  out  1  sticky underflow error.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - rd_data=0, rd_data_t=0, count=0, empty=1, full=0.
  - ovf=0, udf=0, flags_t=0, ctrl_t=0.
  - Pointers=0. All stored data and taint entries cleared to 0.
  - Reset mid-operation discards all contents immediately.
- Write acceptance: wa = wr_en & (~full | ra).
  - A write accepted while full relies on the simultaneous read freeing an entry.
- Read acceptance: ra = rd_en & ~empty.
  - When empty, a simultaneous write is accepted and the read is ignored. There is no fall-through.
- Accepted write:
  - mem[wp] <= wr_data.
  - mem_t[wp] <= wr_data_t | wr_en_t | ctrl_t.
  - wp increments modulo DEPTH.
- Accepted read:
  - rd_data <= mem[rp].
  - rd_data_t <= mem_t[rp] | rd_en_t | ctrl_t.
  - rp increments modulo DEPTH.
  - Latency is 1 cycle: data is valid the cycle after ra.
- No accepted read: rd_data and rd_data_t hold their values.
- Count: count <= count + wa - ra. Both wa and ra in the same cycle leave count unchanged.
- Control taint register (internal, sticky until reset):
  - ctrl_t <= ctrl_t | wr_en_t | rd_en_t on every cycle, whatever the enable values, because pointer state depends on the enable values.
  - flags_t = ctrl_t, combinational from the register.
- Error flags:
  - ovf sets on wr_en & full & ~rd_en.
  - udf sets on rd_en & empty.
  - Both stay set until reset. An overflow or underflow request never changes pointers, count or memory.
- Pointer wrap: pointers are $clog2(DEPTH) bits. full and empty are decoded from count, not from pointer equality.
- No latches: all storage is flip-flops on clk.

Decomposition:
- Package ift_pkg:
  - taint_t (logic [TW-1:0]) and the constant TAINT_NONE = 0.
  - Function taint_or3(a,b,c).
- Sub-module ift_fifo_ctrl:
  - Holds pointers, count, full/empty, ovf/udf and ctrl_t.
  - Outputs wa, ra, wp, rp.
- The top level holds the mem/mem_t arrays and the rd_data/rd_data_t registers.

Test Plan:
- Reset release, then 4 writes of 00,01,10,11 with all taints 0, then 4 reads -> rd_data is 00,01,10,11 on the cycles after each read; all taints 0; count goes 4..0; empty=1 at the end.
- Write 01 with wr_data_t=0x1 and wr_en_t=0x4, then read with rd_en_t=0x10 -> rd_data=01; rd_data_t=0x15; flags_t=0x14.
- Fill to DEPTH=4, then wr_en=1 with rd_en=0 -> ovf=1; count stays 4; memory unchanged. Next, wr_en=rd_en=1 while full -> both accepted; count stays 4; FIFO order preserved across pointer wrap.
- rd_en=1 while empty -> udf=1; rd_data holds. Next, wr_en=rd_en=1 while empty -> count=1; rd_data unchanged.
- Apply rd_en_t=0x2 on one idle cycle (rd_en=0), then write and read data with zero taint -> rd_data_t=0x2; flags_t=0x2. ctrl_t stays sticky until rst_n pulses low.
- Assert rst_n=0 asynchronously between edges with count=3 -> outputs return to reset values immediately. The next read after release is ignored and udf=1.
